// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel frame pipeline.
// Used by the frame sequencer and by the sobel/vga blocks.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    WAIT
  } seq_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sobel_raster_counter.sv
// Raster-order pixel counter with linear index, row and column.
// Wraps to zero after the last pixel of the frame.
module raster_counter
  import sobel_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 128,
  parameter int AW    = clog2(WIDTH * DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  output logic [AW-1:0]            index,
  output logic [clog2(DEPTH)-1:0]  row,
  output logic [clog2(WIDTH)-1:0]  col,
  output logic                     last
);

  localparam int RW = clog2(DEPTH);
  localparam int CW = clog2(WIDTH);

  logic [AW-1:0] idx_q, idx_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          eol;

  assign eol  = (col_q == CW'(WIDTH - 1));
  assign last = eol && (row_q == RW'(DEPTH - 1));

  always_comb begin
    idx_d = idx_q;
    row_d = row_q;
    col_d = col_q;
    if (clr || (en && last)) begin
      idx_d = '0;
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      idx_d = idx_q + AW'(1);
      if (eol) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      idx_q <= idx_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign index = idx_q;
  assign row   = row_q;
  assign col   = col_q;

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame controller: raster reads, window flush, delayed bitmap writes.
// A global stall freezes every counter, the FSM and the write delay line.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 128,
  parameter int PIPE   = 2,
  parameter int ADDR_W = $clog2(WIDTH * DEPTH)
) (
  input  logic              ClkPort,
  input  logic              Reset,
  input  logic              start,
  input  logic [7:0]        thresh_in,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [7:0]        threshold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              win_shift,
  output logic              pipe_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              border
);

  localparam int RW = clog2(DEPTH);
  localparam int CW = clog2(WIDTH);
  localparam logic [PIPE-1:0] LAST_BIT = PIPE'(1) << (PIPE - 1);

  seq_state_e state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] thr_q, thr_d;
  logic       ws_q, ws_d;

  logic [PIPE-1:0]             vld_q, vld_d;
  logic [PIPE-1:0][ADDR_W-1:0] adr_q, adr_d;
  logic [PIPE-1:0]             bdr_q, bdr_d;

  logic              accept, run, flush, produce, past_head, drain_done;
  logic [ADDR_W-1:0] rk_idx, wj_idx;
  logic [RW-1:0]     rk_row, wj_row;
  logic [CW-1:0]     rk_col, wj_col;
  logic              rk_last, wj_last, wj_border;

  raster_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(ADDR_W)) u_rd_cnt (
    .clk   (ClkPort),
    .rst   (Reset),
    .en    (run && !stall),
    .clr   (accept),
    .index (rk_idx),
    .row   (rk_row),
    .col   (rk_col),
    .last  (rk_last)
  );

  raster_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(ADDR_W)) u_wr_cnt (
    .clk   (ClkPort),
    .rst   (Reset),
    .en    (produce),
    .clr   (accept),
    .index (wj_idx),
    .row   (wj_row),
    .col   (wj_col),
    .last  (wj_last)
  );

  assign accept = (state_q == IDLE) && start && !busy_q;
  assign run    = (state_q == RUN);
  assign flush  = (state_q == FLUSH);

  // window holds a full output once read index reaches WIDTH+1
  assign past_head = (rk_row > RW'(1)) ||
                     ((rk_row == RW'(1)) && (rk_col != '0));
  assign produce   = !stall && ((run && past_head) || flush);

  assign wj_border = (wj_row == '0) || (wj_row == RW'(DEPTH - 1)) ||
                     (wj_col == '0) || (wj_col == CW'(WIDTH - 1));

  assign drain_done = (state_q == WAIT) && !stall &&
                      ((vld_q & ~LAST_BIT) == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (!stall && rk_last) state_d = FLUSH;
      FLUSH:   if (produce && wj_last) state_d = WAIT;
      WAIT:    if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = drain_done;
    busy_d = (state_d != IDLE) || drain_done;
    thr_d  = accept ? thresh_in : thr_q;
    ws_d   = stall ? ws_q : (run || flush);
  end

  always_comb begin
    vld_d = vld_q;
    adr_d = adr_q;
    bdr_d = bdr_q;
    if (!stall) begin
      for (int i = PIPE - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        adr_d[i] = adr_q[i-1];
        bdr_d[i] = bdr_q[i-1];
      end
      vld_d[0] = produce;
      adr_d[0] = wj_idx;
      bdr_d[0] = wj_border;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      thr_q   <= '0;
      ws_q    <= 1'b0;
      vld_q   <= '0;
      adr_q   <= '0;
      bdr_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      thr_q   <= thr_d;
      ws_q    <= ws_d;
      vld_q   <= vld_d;
      adr_q   <= adr_d;
      bdr_q   <= bdr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign threshold = thr_q;
  assign rd_en     = run && !stall;
  assign rd_addr   = rk_idx;
  assign win_shift = ws_q && !stall;
  assign pipe_en   = !stall;
  assign wr_en     = vld_q[PIPE-1] && !stall;
  assign wr_addr   = adr_q[PIPE-1];
  assign border    = bdr_q[PIPE-1];

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer at WIDTH=DEPTH=4, PIPE=2.
// Logs reads/writes/done per cycle and compares against hand timing.
module tb_sobel_frame_sequencer;

  logic       ClkPort = 1'b0;
  logic       Reset   = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] thresh_in = 8'h00;
  logic       stall   = 1'b0;
  logic       busy, done, rd_en, win_shift, pipe_en, wr_en, border;
  logic [7:0] threshold;
  logic [3:0] rd_addr, wr_addr;

  sobel_frame_sequencer #(.WIDTH(4), .DEPTH(4), .PIPE(2)) dut (
    .ClkPort   (ClkPort),
    .Reset     (Reset),
    .start     (start),
    .thresh_in (thresh_in),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .threshold (threshold),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .win_shift (win_shift),
    .pipe_en   (pipe_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .border    (border)
  );

  always #5 ClkPort = ~ClkPort;

  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;
  bit active = 1'b0;

  int rd_c[64], rd_a[64], n_rd;
  int wr_c[64], wr_a[64], wr_b[64], n_wr;
  int dn_c[8], n_dn;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // cycle of the n-th unstalled cycle after the start cycle
  function automatic int act(input int n, input int lo, input int hi);
    int cnt = 0;
    for (int a = 1; a < 200; a++) begin
      if (!(a >= lo && a <= hi)) cnt++;
      if (cnt == n) return a;
    end
    return -1;
  endfunction

  always @(negedge ClkPort) begin
    if (active && !Reset) begin
      chk("pipe_en", int'(pipe_en), int'(!stall));
      if (rd_en) begin
        if (n_rd < 64) begin
          rd_c[n_rd] = cur_cyc;
          rd_a[n_rd] = int'(rd_addr);
        end
        n_rd++;
      end
      if (wr_en) begin
        if (n_wr < 64) begin
          wr_c[n_wr] = cur_cyc;
          wr_a[n_wr] = int'(wr_addr);
          wr_b[n_wr] = int'(border);
        end
        n_wr++;
      end
      if (done) begin
        if (n_dn < 8) dn_c[n_dn] = cur_cyc;
        n_dn++;
      end
    end
  end

  task automatic reset_checks();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_threshold", int'(threshold), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_win_shift", int'(win_shift), 0);
    chk("rst_pipe_en", int'(pipe_en), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_border", int'(border), 0);
  endtask

  task automatic run_frame(input logic [7:0] th, input int lo, input int hi,
                           input int e1, input int e2, input int rst_at);
    n_rd = 0;
    n_wr = 0;
    n_dn = 0;
    active = 1'b1;
    for (int c = 0; c < 32; c++) begin
      cur_cyc   = c;
      start     = (c == 0 || c == e1 || c == e2);
      stall     = (c >= lo && c <= hi);
      thresh_in = (c == 0) ? th : 8'hFF;
      if (c == rst_at) begin
        #2 Reset = 1'b1;
        #1 reset_checks();
      end
      if (rst_at >= 0 && c == rst_at + 1) Reset = 1'b0;
      if (rst_at < 0 && c == 10) chk("thr_mid", int'(threshold), int'(th));
      @(posedge ClkPort);
      #1;
    end
    start  = 1'b0;
    stall  = 1'b0;
    active = 1'b0;
  endtask

  task automatic check_frame(input int lo, input int hi);
    int r, cl, bexp;
    chk("n_reads", n_rd, 16);
    for (int k = 0; k < 16 && k < n_rd; k++) begin
      chk($sformatf("rd_addr[%0d]", k), rd_a[k], k);
      chk($sformatf("rd_cyc[%0d]", k), rd_c[k], act(1 + k, lo, hi));
    end
    chk("n_writes", n_wr, 16);
    for (int j = 0; j < 16 && j < n_wr; j++) begin
      r    = j / 4;
      cl   = j % 4;
      bexp = (r == 0 || r == 3 || cl == 0 || cl == 3) ? 1 : 0;
      chk($sformatf("wr_addr[%0d]", j), wr_a[j], j);
      chk($sformatf("wr_cyc[%0d]", j), wr_c[j], act(j + 8, lo, hi));
      chk($sformatf("border[%0d]", j), wr_b[j], bexp);
    end
    chk("n_done", n_dn, 1);
    if (n_dn > 0) chk("done_cyc", dn_c[0], act(24, lo, hi));
    chk("busy_end", int'(busy), 0);
  endtask

  initial begin
    #3 reset_checks();
    repeat (2) @(posedge ClkPort);
    #1 Reset = 1'b0;
    @(posedge ClkPort);
    #1;

    // plain frame; thresh_in changes to 0xFF after start
    run_frame(8'h33, -1, -2, -1, -1, -1);
    check_frame(-1, -2);
    chk("thr_hold", int'(threshold), 8'h33);

    // stall cycles 10..12
    run_frame(8'h44, 10, 12, -1, -1, -1);
    check_frame(10, 12);

    // extra start pulses while busy
    run_frame(8'h55, -1, -2, 5, 20, -1);
    check_frame(-1, -2);
    chk("thr_third", int'(threshold), 8'h55);

    // reset mid-frame abandons it
    run_frame(8'h66, -1, -2, -1, -1, 9);
    chk("rst_n_done", n_dn, 0);
    chk("rst_n_reads", n_rd, 8);
    chk("rst_n_writes", n_wr, 1);
    run_frame(8'h77, -1, -2, -1, -1, -1);
    check_frame(-1, -2);

    // start while stalled, release at cycle 4
    run_frame(8'h88, 0, 3, -1, -1, -1);
    check_frame(0, 3);
    chk("thr_last", int'(threshold), 8'h88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
